// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file write scheduler.
package regfile_ctrl_pkg;

    // Default register-file geometry (8 registers of 32 bits).
    localparam int RF_AW    = 3;
    localparam int RF_DW    = 32;
    localparam int RF_NREGS = 8;

    // Requester indices are carried on 3 bits so up to 8 requesters fit.
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    // Clear sequencer states.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request
// starting at ptr and wrapping modulo N. Produces one-hot and encoded grants.
module rr_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [MAX_REQ-1:0] req_ext;
    logic [IDX_W-1:0]   cand_idx [N];
    logic [N-1:0]       cand_vld;
    logic               any_vld;
    logic [IDX_W-1:0]   first_idx;

    // Widen to the full index range so any 3-bit index addresses a real bit.
    assign req_ext = MAX_REQ'(req);

    // Candidate gi is the requester gi positions after ptr, wrapped modulo N.
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum          = {1'b0, ptr} + (IDX_W+1)'(gi);
        assign cand_idx[gi] = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                     : sum[IDX_W-1:0];
        assign cand_vld[gi] = req_ext[cand_idx[gi]];
    end

    // Priority scan over candidates; the nearest one to ptr wins.
    always_comb begin
        any_vld   = 1'b0;
        first_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand_vld[k]) begin
                any_vld   = 1'b1;
                first_idx = cand_idx[k];
            end
        end
    end

    assign grant_valid = enable && any_vld;
    assign grant_idx   = first_idx;

    // One-hot grant decode.
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
        assign grant[gi] = grant_valid && (first_idx == IDX_W'(gi));
    end

endmodule

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the register file: round-robin arbitration of
// N_REQ requesters onto one registered write port, plus a clear sequencer
// that zeroes every register, one per cycle.
module regfile_wr_sched
    import regfile_ctrl_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int AW         = RF_AW,
    parameter int DW         = RF_DW,
    parameter int NREGS      = RF_NREGS,
    parameter int PROTECT_R0 = 0
) (
    input  logic                clk,
    input  logic                cr,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic                clr_start,
    output logic                clr_busy,
    output logic                clr_done,
    output logic                rf_we,
    output logic [AW-1:0]       rf_waddr,
    output logic [DW-1:0]       rf_wdata,
    output logic [2:0]          grant_id
);

    clr_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             rf_we_q, rf_we_d;
    logic [AW-1:0]    rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]    rf_wdata_q, rf_wdata_d;
    logic [IDX_W-1:0] grant_id_q, grant_id_d;
    logic             clr_done_q, clr_done_d;

    logic [AW-1:0]    addr_arr [MAX_REQ];
    logic [DW-1:0]    data_arr [MAX_REQ];
    logic             arb_enable;
    logic [N_REQ-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;
    logic             sel_suppress;

    // Split the packed request buses into per-requester entries; unused
    // slots up to MAX_REQ are tied off so any 3-bit index is safe.
    for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_unpack
        if (gi < N_REQ) begin : g_live
            assign addr_arr[gi] = req_addr[gi*AW +: AW];
            assign data_arr[gi] = req_data[gi*DW +: DW];
        end else begin : g_tie
            assign addr_arr[gi] = '0;
            assign data_arr[gi] = '0;
        end
    end

    // Requests are only served in IDLE when no clear is being started,
    // and never while reset is asserted.
    assign arb_enable = (state_q == IDLE) && !clr_start && !cr;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req         (req_valid),
        .ptr         (ptr_q),
        .enable      (arb_enable),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    assign req_ready    = arb_grant;
    assign sel_addr     = addr_arr[arb_idx];
    assign sel_data     = data_arr[arb_idx];
    assign sel_suppress = (PROTECT_R0 != 0) && (sel_addr == '0);

    // Next-state logic for the clear FSM, pointer, counter and write port.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        grant_id_d = grant_id_q;
        clr_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    // First clear write (address 0) issues straight away.
                    state_d    = CLEAR;
                    rf_we_d    = 1'b1;
                    rf_waddr_d = '0;
                    rf_wdata_d = '0;
                    cnt_d      = AW'(1);
                end else if (arb_valid) begin
                    ptr_d = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                    // A protected write to register 0 is accepted but dropped.
                    if (!sel_suppress) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = sel_addr;
                        rf_wdata_d = sel_data;
                        grant_id_d = arb_idx;
                    end
                end
            end
            CLEAR: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = cnt_q;
                rf_wdata_d = '0;
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (cr) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            grant_id_q <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            grant_id_q <= grant_id_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign grant_id = grant_id_q;
    assign clr_done = clr_done_q;
    assign clr_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched: a vector table for arbitration and
// hand-written sequences for reset, clear, reset-mid-clear and R0 protection.
module tb_regfile_wr_sched;

    logic         clk;
    logic         cr;
    logic [3:0]   req_valid;
    logic [11:0]  req_addr;
    logic [127:0] req_data;
    logic         clr_start;

    logic [3:0]   req_ready,  p_req_ready;
    logic         clr_busy,   p_clr_busy;
    logic         clr_done,   p_clr_done;
    logic         rf_we,      p_rf_we;
    logic [2:0]   rf_waddr,   p_rf_waddr;
    logic [31:0]  rf_wdata,   p_rf_wdata;
    logic [2:0]   grant_id,   p_grant_id;

    int total = 0;
    int bad   = 0;

    regfile_wr_sched dut (
        .clk       (clk),
        .cr        (cr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .grant_id  (grant_id)
    );

    regfile_wr_sched #(
        .PROTECT_R0 (1)
    ) dut_p (
        .clk       (clk),
        .cr        (cr),
        .req_valid (req_valid),
        .req_ready (p_req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .clr_start (clr_start),
        .clr_busy  (p_clr_busy),
        .clr_done  (p_clr_done),
        .rf_we     (p_rf_we),
        .rf_waddr  (p_rf_waddr),
        .rf_wdata  (p_rf_wdata),
        .grant_id  (p_grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0]  valid;
        logic [11:0] addr;
        logic [7:0]  seed;
        logic [3:0]  e_ready;
        logic        e_we;
        logic [2:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [2:0]  e_gid;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requester i carries {seed, 0xA, i, 0x5A5A}.
    function automatic logic [127:0] mk_data(input logic [7:0] seed);
        logic [127:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) d[i*32 +: 32] = {seed, 4'hA, 4'(i), 16'h5A5A};
        return d;
    endfunction

    task automatic add(input logic [3:0] v, input logic [11:0] a, input logic [7:0] s,
                       input logic [3:0] er, input logic ew, input logic [2:0] ewa,
                       input logic [31:0] ewd, input logic [2:0] eg);
        vec_t t;
        t = '{v, a, s, er, ew, ewa, ewd, eg};
        tbl.push_back(t);
    endtask

    initial begin
        // Table: each row = inputs for a cycle and outputs seen in that cycle
        // (ready is combinational, rf_* shows the previous cycle's grant).
        // Fairness from ptr=0, all four valid.
        add(4'b1111, 12'o4321, 8'h10, 4'b0001, 1'b0, 3'd0, 32'h00000000, 3'd0);
        add(4'b1111, 12'o4321, 8'h10, 4'b0010, 1'b1, 3'd1, 32'h10A05A5A, 3'd0);
        add(4'b1111, 12'o4321, 8'h10, 4'b0100, 1'b1, 3'd2, 32'h10A15A5A, 3'd1);
        add(4'b1111, 12'o4321, 8'h10, 4'b1000, 1'b1, 3'd3, 32'h10A25A5A, 3'd2);
        add(4'b1111, 12'o4321, 8'h10, 4'b0001, 1'b1, 3'd4, 32'h10A35A5A, 3'd3);
        add(4'b1111, 12'o4321, 8'h10, 4'b0010, 1'b1, 3'd1, 32'h10A05A5A, 3'd0);
        add(4'b1111, 12'o4321, 8'h10, 4'b0100, 1'b1, 3'd2, 32'h10A15A5A, 3'd1);
        add(4'b1111, 12'o4321, 8'h10, 4'b1000, 1'b1, 3'd3, 32'h10A25A5A, 3'd2);
        add(4'b0000, 12'o4321, 8'h10, 4'b0000, 1'b1, 3'd4, 32'h10A35A5A, 3'd3);
        add(4'b0000, 12'o4321, 8'h10, 4'b0000, 1'b0, 3'd4, 32'h10A35A5A, 3'd3);
        // Skipping idle requesters (1 and 3 valid), ptr=0.
        add(4'b1010, 12'o4321, 8'h20, 4'b0010, 1'b0, 3'd4, 32'h10A35A5A, 3'd3);
        add(4'b1010, 12'o4321, 8'h20, 4'b1000, 1'b1, 3'd2, 32'h20A15A5A, 3'd1);
        add(4'b1010, 12'o4321, 8'h20, 4'b0010, 1'b1, 3'd4, 32'h20A35A5A, 3'd3);
        add(4'b0000, 12'o4321, 8'h20, 4'b0000, 1'b1, 3'd2, 32'h20A15A5A, 3'd1);
        // Requester 0 changes data each cycle; only accept-cycle data is used. ptr=2.
        add(4'b1001, 12'o4321, 8'h31, 4'b1000, 1'b0, 3'd2, 32'h20A15A5A, 3'd1);
        add(4'b1001, 12'o4321, 8'h32, 4'b0001, 1'b1, 3'd4, 32'h31A35A5A, 3'd3);
        add(4'b0001, 12'o4321, 8'h33, 4'b0001, 1'b1, 3'd1, 32'h32A05A5A, 3'd0);
        add(4'b0000, 12'o4321, 8'h34, 4'b0000, 1'b1, 3'd1, 32'h33A05A5A, 3'd0);
        // Same address from two requesters back to back. ptr=1.
        add(4'b0011, 12'o7777, 8'h40, 4'b0010, 1'b0, 3'd1, 32'h33A05A5A, 3'd0);
        add(4'b0011, 12'o7777, 8'h41, 4'b0001, 1'b1, 3'd7, 32'h40A15A5A, 3'd1);
        add(4'b0000, 12'o7777, 8'h42, 4'b0000, 1'b1, 3'd7, 32'h41A05A5A, 3'd0);
        add(4'b0000, 12'o7777, 8'h42, 4'b0000, 1'b0, 3'd7, 32'h41A05A5A, 3'd0);

        // Reset state, with all requesters valid to show ready is forced low.
        cr        = 1'b1;
        clr_start = 1'b0;
        req_valid = 4'b1111;
        req_addr  = 12'o4321;
        req_data  = mk_data(8'h00);
        tick();
        tick();
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_we", 32'(rf_we), 32'h0);
        chk("rst_waddr", 32'(rf_waddr), 32'h0);
        chk("rst_wdata", rf_wdata, 32'h0);
        chk("rst_gid", 32'(grant_id), 32'h0);
        chk("rst_busy", 32'(clr_busy), 32'h0);
        chk("rst_done", 32'(clr_done), 32'h0);
        tick();

        // Single request from requester 2.
        cr        = 1'b0;
        req_valid = 4'b0100;
        req_addr  = 12'o0500;
        req_data  = {32'h0, 32'hDEADBEEF, 64'h0};
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("single_we", 32'(rf_we), 32'h1);
        chk("single_waddr", 32'(rf_waddr), 32'h5);
        chk("single_wdata", rf_wdata, 32'hDEADBEEF);
        chk("single_gid", 32'(grant_id), 32'h2);
        chk("single_ready_off", 32'(req_ready), 32'h0);
        tick();
        @(negedge clk);
        chk("single_we_off", 32'(rf_we), 32'h0);
        tick();

        // Reset again so the table starts from ptr=0.
        cr = 1'b1;
        tick();
        cr = 1'b0;

        foreach (tbl[n]) begin
            req_valid = tbl[n].valid;
            req_addr  = tbl[n].addr;
            req_data  = mk_data(tbl[n].seed);
            @(negedge clk);
            chk($sformatf("v%0d_ready", n), 32'(req_ready), 32'(tbl[n].e_ready));
            chk($sformatf("v%0d_we", n), 32'(rf_we), 32'(tbl[n].e_we));
            chk($sformatf("v%0d_waddr", n), 32'(rf_waddr), 32'(tbl[n].e_waddr));
            chk($sformatf("v%0d_wdata", n), rf_wdata, tbl[n].e_wdata);
            chk($sformatf("v%0d_gid", n), 32'(grant_id), 32'(tbl[n].e_gid));
            tick();
        end

        // Clear sequence with requester 1 waiting; ptr=1.
        clr_start = 1'b1;
        req_valid = 4'b0010;
        req_addr  = 12'o4321;
        req_data  = mk_data(8'h50);
        @(negedge clk);
        chk("clr_t_ready", 32'(req_ready), 32'h0);
        chk("clr_t_busy", 32'(clr_busy), 32'h0);
        tick();
        clr_start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("clr%0d_we", k), 32'(rf_we), 32'h1);
            chk($sformatf("clr%0d_waddr", k), 32'(rf_waddr), 32'(k - 1));
            chk($sformatf("clr%0d_wdata", k), rf_wdata, 32'h0);
            chk($sformatf("clr%0d_busy", k), 32'(clr_busy), (k <= 7) ? 32'h1 : 32'h0);
            chk($sformatf("clr%0d_done", k), 32'(clr_done), (k == 8) ? 32'h1 : 32'h0);
            chk($sformatf("clr%0d_ready", k), 32'(req_ready), (k == 8) ? 32'h2 : 32'h0);
            chk($sformatf("clr%0d_p_we", k), 32'(p_rf_we), 32'h1);
            tick();
        end
        req_valid = 4'b0000;
        @(negedge clk);
        chk("clr_after_we", 32'(rf_we), 32'h1);
        chk("clr_after_waddr", 32'(rf_waddr), 32'h2);
        chk("clr_after_wdata", rf_wdata, 32'h50A15A5A);
        chk("clr_after_gid", 32'(grant_id), 32'h1);
        chk("clr_after_done", 32'(clr_done), 32'h0);
        tick();

        // Reset at cycle u+3 of a clear.
        clr_start = 1'b1;
        @(negedge clk);
        tick();
        clr_start = 1'b0;
        tick();
        tick();
        cr        = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("midrst_busy_before", 32'(clr_busy), 32'h1);
        chk("midrst_ready", 32'(req_ready), 32'h0);
        tick();
        cr        = 1'b0;
        req_valid = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("midrst%0d_we", k), 32'(rf_we), 32'h0);
            chk($sformatf("midrst%0d_busy", k), 32'(clr_busy), 32'h0);
            chk($sformatf("midrst%0d_done", k), 32'(clr_done), 32'h0);
            tick();
        end
        req_valid = 4'b1111;
        req_data  = mk_data(8'h60);
        @(negedge clk);
        chk("postrst_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("postrst_we", 32'(rf_we), 32'h1);
        chk("postrst_waddr", 32'(rf_waddr), 32'h1);
        chk("postrst_wdata", rf_wdata, 32'h60A05A5A);
        chk("postrst_gid", 32'(grant_id), 32'h0);
        tick();

        // Register-0 protection: requester 0 to addr 0, then requester 3 to addr 7.
        req_valid = 4'b0001;
        req_addr  = 12'o7000;
        req_data  = {32'h77770003, 32'h0, 32'h0, 32'h00001234};
        @(negedge clk);
        chk("prot_ready0", 32'(p_req_ready), 32'h1);
        tick();
        req_valid = 4'b1000;
        @(negedge clk);
        chk("prot_we0", 32'(p_rf_we), 32'h0);
        chk("noprot_we0", 32'(rf_we), 32'h1);
        chk("noprot_waddr0", 32'(rf_waddr), 32'h0);
        chk("noprot_wdata0", rf_wdata, 32'h00001234);
        chk("prot_ready3", 32'(p_req_ready), 32'h8);
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("prot_we7", 32'(p_rf_we), 32'h1);
        chk("prot_waddr7", 32'(p_rf_waddr), 32'h7);
        chk("prot_wdata7", p_rf_wdata, 32'h77770003);
        chk("prot_gid7", 32'(p_grant_id), 32'h3);
        tick();
        @(negedge clk);
        chk("prot_we_off", 32'(p_rf_we), 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wr_sched.md
Name: regfile_wr_sched

Overview:
Write-port scheduler for the 8x32 register file.
- Arbitrates N_REQ independent write requesters onto the file's single write port. Policy is round-robin, at most one write per cycle.
- Drives write-enable, write-address and write-data from registered outputs.
- Contains a clear sequencer that zeroes all registers, one per cycle, when started by software or a control FSM.

Parameters:
N_REQ, 4, number of write requesters (2..8)
AW, 3, register address width
DW, 32, register data width
NREGS, 8, registers covered by the clear sequence (2**AW)
PROTECT_R0, 0, 1 = requester writes to address 0 are accepted but suppressed (rf_we stays 0)

Ports:
clk  in  1  clock; all state updates on rising edge
cr  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester write request
req_ready  out  N_REQ  per-requester accept; one-hot or zero
req_addr  in  N_REQ*AW  packed target addresses; requester i at [i*AW +: AW]
req_data  in  N_REQ*DW  packed write data; requester i at [i*DW +: DW]
clr_start  in  1  start clear sequence (level sampled in IDLE)
clr_busy  out  1  clear in progress
clr_done  out  1  one-cycle pulse on the final clear write
rf_we  out  1  register-file write enable
rf_waddr  out  AW  register-file write address
rf_wdata  out  DW  register-file write data
grant_id  out  3  index of the requester whose write is currently on rf_*

Behaviour:
- Reset (cr=1 at an edge):
  - rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0, clr_busy=0, clr_done=0.
  - FSM goes to IDLE; round-robin pointer ptr=0; clear counter cnt=0.
  - While cr=1, req_ready is forced to 0.
  - Reset mid-clear aborts the sequence; no clr_done is produced.
- Handshake:
  - A transfer occurs in a cycle where req_valid[i] && req_ready[i].
  - req_ready is combinational from req_valid, ptr and state. It never depends on rf_* outputs.
  - A requester may hold valid with changing addr/data until accepted. Only the values present in the accept cycle are used.
- Arbitration, IDLE and clr_start=0:
  - Grant the first i with req_valid[i]=1, searching ptr, ptr+1, ... mod N_REQ.
  - Raise req_ready[i] for that requester only.
  - On grant, ptr <= (i+1) mod N_REQ. With no valid requester, ptr holds.
- Latency: a transfer in cycle t produces rf_we=1, rf_waddr=addr, rf_wdata=data, grant_id=i in cycle t+1. The register file captures it at the end of t+1. Throughput is one write per cycle, with no bubbles between back-to-back grants.
- No grant in a cycle: rf_we=0 next cycle; rf_waddr, rf_wdata and grant_id hold their previous values.
- PROTECT_R0=1 and accepted addr==0: ready handshake completes and ptr advances, but rf_we=0 next cycle.
- Clear FSM states: IDLE, CLEAR.
  - IDLE, clr_start=1 in cycle t: all req_ready=0 (clear wins over requests). At the edge, state<=CLEAR, rf_we<=1, rf_waddr<=0, rf_wdata<=0, cnt<=1.
  - CLEAR: all req_ready=0; clr_start ignored. Each edge writes rf_waddr<=cnt, rf_wdata<=0, rf_we<=1. When cnt==NREGS-1, state<=IDLE and clr_done<=1; otherwise cnt++.
  - Result: writes to addresses 0..7 appear on cycles t+1..t+8. clr_busy is high t+1..t+7 (state==CLEAR), and clr_done is high in t+8.
  - Requesters can be accepted from t+8; their first write appears in t+9.
  - Clear writes ignore PROTECT_R0, so address 0 is written as 0.
  - ptr is unchanged by a clear.
- clr_start held high continuously: the clear restarts from IDLE each time it returns. This results in one idle-for-requests cycle (t+8) between sequences.
- A same-address write from the same or different requesters in consecutive cycles issues both, in grant order. The last write wins.

Decomposition:
- Package regfile_ctrl_pkg: AW, DW, NREGS constants; state type {IDLE, CLEAR}; requester-index width.
- Sub-module rr_arbiter: parameterised N; inputs req, ptr, enable; outputs one-hot grant and encoded index. It is purely combinational.
- regfile_wr_sched holds the FSM, ptr, cnt and the output registers.

Test Plan:
- Single request: after reset, requester 2 valid addr=5 data=0xDEADBEEF for one cycle -> req_ready=4'b0100 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, grant_id=2; following cycle rf_we=0.
- Fairness: all 4 requesters hold valid with distinct addr/data for 8 cycles, from ptr=0 -> grant order 0,1,2,3,0,1,2,3; rf_we high 8 consecutive cycles, each shifted by one from its grant.
- Clear: pulse clr_start at cycle t with requester 1 valid -> req_ready=0 during t..t+7; rf_waddr 0..7 with rf_wdata=0 on t+1..t+8; clr_busy high t+1..t+7; clr_done only at t+8; requester 1 accepted at t+8, its write at t+9.
- Reset mid-clear: cr=1 for one cycle at cycle t+3 of a clear -> following cycle rf_we=0, clr_busy=0, no clr_done; then a new request issues normally with ptr=0.
- PROTECT_R0=1: requester 0 writes addr=0 data=0x1234 -> handshake completes, next cycle rf_we=0. Requester 3 writes addr=7 -> rf_we=1, rf_waddr=7.
- Backpressure/hold: requester 0 changes data each cycle while requester 3 holds the grant via ptr -> the write issued for requester 0 carries the data present in its accept cycle only.
